// File: rtl/layer_sequencer.sv
// Control FSM that time-multiplexes one fully-connected layer datapath across
// up to NUM_LAYERS layers, feeding each layer's result back as the next input.
module layer_sequencer #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LAYERS = 4,
  parameter int DP_LATENCY = 1,
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int CW         = $clog2(NUM_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic [CW-1:0]           cfg_layers,
  output logic [N*DATA_WIDTH-1:0] layer_in,
  output logic [LW-1:0]           layer_sel,
  input  logic [N*DATA_WIDTH-1:0] layer_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    busy
);

  localparam int VW  = N * DATA_WIDTH;
  localparam int CNW = $clog2(DP_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [VW-1:0]   act, act_d;
  logic [VW-1:0]   lin_q, lin_d;
  logic [LW-1:0]   idx, idx_d;
  logic [LW-1:0]   lsel_q, lsel_d;
  logic [LW-1:0]   last, last_d;
  logic [CNW-1:0]  cnt, cnt_d;
  logic [CW-1:0]   eff;

  always_comb begin
    if (cfg_layers == '0)
      eff = CW'(1);
    else if (cfg_layers > CW'(NUM_LAYERS))
      eff = CW'(NUM_LAYERS);
    else
      eff = cfg_layers;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      act    <= '0;
      lin_q  <= '0;
      idx    <= '0;
      lsel_q <= '0;
      last   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      act    <= act_d;
      lin_q  <= lin_d;
      idx    <= idx_d;
      lsel_q <= lsel_d;
      last   <= last_d;
      cnt    <= cnt_d;
    end
  end

  // layer_in/layer_sel have their own registers so they hold the last layer's
  // operands while act carries the final result through DONE and IDLE.
  always_comb begin
    state_d = state;
    act_d   = act;
    lin_d   = lin_q;
    idx_d   = idx;
    lsel_d  = lsel_q;
    last_d  = last;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          act_d   = in_data;
          lin_d   = in_data;
          idx_d   = '0;
          lsel_d  = '0;
          cnt_d   = '0;
          last_d  = LW'(eff - CW'(1));
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == CNW'(DP_LATENCY)) begin
          act_d = layer_out;
          cnt_d = '0;
          if (idx == last) begin
            state_d = DONE;
          end else begin
            idx_d  = idx + LW'(1);
            lsel_d = idx + LW'(1);
            lin_d  = layer_out;
          end
        end else begin
          cnt_d = cnt + CNW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = act;
  assign layer_in  = lin_q;
  assign layer_sel = lsel_q;

endmodule
